// File: rtl/icache_direct_if.sv
// Fetch-side bus of the instruction cache: the datapath request/response
// pair and the memory-controller read handshake.
interface icache_direct_if #(
  parameter int WORD_W = 32
);
  // datapath side
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  // memory controller side
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  // cache end of the bus
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // surrounding system end of the bus (datapath + controller)
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word blocks.
// Hits are answered combinationally in IDLE; a miss fetches one word from
// the controller in FETCH and fills the frame, after which IDLE re-evaluates.
module icache_direct #(
  parameter  int SETS   = 16,
  parameter  int WORD_W = 32,
  localparam int IDX_W  = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_direct_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] miss_addr;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_store  [SETS];
  logic [WORD_W-1:0] data_store [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              miss_start;
  logic              fill_en;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[WORD_W-1:IDX_W+2];

  assign lookup_hit = bus.imemREN && valid[req_idx] && (tag_store[req_idx] == req_tag);
  // The fill only lands on a completed transfer; iwait outside FETCH is ignored.
  assign fill_en    = (state == FETCH) && !bus.iwait;

  // Next-state and output decode; ihit is forced low in FETCH so fill and lookup never overlap.
  always_comb begin
    state_n      = state;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    miss_start   = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_store[req_idx];
        end else if (bus.imemREN) begin
          miss_start = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
        if (!bus.iwait) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state: FSM, latched miss address, frame valid bits and counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_n;
      if (miss_start) begin
        miss_addr  <= {bus.imemaddr[WORD_W-1:2], 2'b00};
        miss_count <= miss_count + 32'd1;
      end
      if (bus.ihit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_store[fill_idx]  <= fill_tag;
      data_store[fill_idx] <= bus.iload;
    end
  end

endmodule
